seg2_capture: RTL and testbench
===============================

# seg2_capture

Reader for the two-digit multiplexed 7-segment bus: samples a time-multiplexed tens/units segment stream, decodes each digit pattern back to BCD, and reconstructs the binary value 0..59. A new value is published only after it has been seen for `STABLE_FRAMES` consecutive frames. The block sits on the display side of the minutes/seconds datapath and serves loopback self-check and board-level display monitoring.

## Interface
- `STABLE_FRAMES`, 3: consecutive identical frames required before `value` updates (range 1..15).
- `SETTLE`, 2: cycles after a strobe rising edge before `seg_in` is sampled (range 1..255).
- `WIDTH`, 6: width of `value`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `seg_in` in 7: segment lines `abcdefg`, active-high, `a` = bit 6 (digit 0 = `1111110`).
- `dig_strobe` in 2: bit 1 = tens digit enabled, bit 0 = units digit enabled; `00` = blanking.
- `value` out WIDTH: last stable value, tens*10+units.
- `tens_bcd` out 4: tens digit of `value`.
- `units_bcd` out 4: units digit of `value`.
- `value_valid` out 1: level; high once any stable value has been published.
- `update` out 1: one-cycle pulse when `value` changes.
- `err` out 1: one-cycle pulse on a discarded frame or digit.

## Operation
- Decode table, patterns only: 0=`1111110`, 1=`0110000`, 2=`1101101`, 3=`1111001`, 4=`0110011`, 5=`1011011`, 6=`1011111`, 7=`1110000`, 8=`1111111`, 9=`1111011`. Any other pattern is illegal.
- Tens digits 6..9 are illegal, because the value range is 0..59.
- Strobe edge detect uses `dig_strobe` registered once (`strobe_q`).
- A rising edge is `dig_strobe[i]=1` with `strobe_q[i]=0`.
- On a rising edge, a settle counter loads. The digit is captured at the `SETTLE`-th edge after the rising edge, provided `dig_strobe[i]` stayed high throughout.
- If the strobe drops early, nothing is captured and no `err` is raised.
- `dig_strobe=11` on any cycle pulses `err`, aborts the settle count and returns the FSM to IDLE.
- Frame FSM:
  - IDLE: a tens capture with a legal pattern goes to HAVE_TENS. A units capture is ignored with no error. An illegal tens pattern pulses `err` and stays in IDLE.
  - HAVE_TENS: a units capture completes the frame and returns to IDLE. A repeated tens capture overwrites the stored tens digit. An illegal pattern on either digit pulses `err` and returns to IDLE.
- Stability tracking uses a candidate value `cand` and a counter `cnt` (4 bits, saturating at `STABLE_FRAMES`).
  - Legal frame equal to `cand`: `cnt++`.
  - Legal frame different from `cand`: `cand` takes the new value and `cnt=1`.
  - Any `err`: `cnt=0`.
- Publish rule: on the frame where `cnt` reaches `STABLE_FRAMES`:
  - If `cand != value` or `value_valid=0`, load `value`, `tens_bcd` and `units_bcd`, set `value_valid`, and pulse `update`.
  - If the frame repeats an already published value, there is no new `update`.
- `value` is computed as tens*10+units in 6 bits. Maximum is 59, so there is no overflow.
- Reset values:
  - `value=0`, `tens_bcd=0`, `units_bcd=0`.
  - `value_valid=0`, `update=0`, `err=0`.
  - FSM=IDLE, `cand=0`, `cnt=0`, `strobe_q=00`.
- Reset mid-frame discards all partial captures. `value_valid` stays 0 until `STABLE_FRAMES` new frames have been seen.

## Timing
- The rising edge is seen at edge E. `seg_in` is sampled at edge E+`SETTLE`, which is the capture edge C.
- `err` for a bad pattern is high in the cycle after C, for exactly 1 cycle.
- `err` for simultaneous strobes is high in the cycle after the edge at which `11` is sampled.
- Frame completion at units capture edge C: `cand`/`cnt` update at C. `value`, `tens_bcd`, `units_bcd`, `value_valid` and `update` change at edge C+1. `update` is high for one cycle.
- Latency from the first strobe edge of the tens digit to `update` is at least `STABLE_FRAMES` frames plus 1 cycle.
- A units capture and a tens rising edge in the same cycle are both processed: the frame completes, and the new tens settle count starts.
- The block has no back-pressure and accepts a new strobe every cycle.

## Test plan
- Stable frames: with `SETTLE=2` and `STABLE_FRAMES=3`, drive tens=`0110011` and units=`1011011` for 3 frames. Expect `value=45`, `tens_bcd=4`, `units_bcd=5`, `value_valid=1`, and one `update` pulse one cycle after the 3rd units capture. Frames 1-2 give no `update`; a 4th identical frame gives no `update`.
- Value change: after 45 is published, drive 2 frames of 59 and then 1 frame of 45. Expect no `update` and `value` still 45. Then drive 3 frames of 59. Expect `update` and `value=59`.
- Illegal patterns: drive tens=`1011111` (6). Expect one `err` pulse and the FSM in IDLE. Drive units=`0000001`. Expect `err` and `cnt=0`, so 3 fresh frames are needed before `update`.
- Strobe hazards:
  - A tens strobe high for only 1 cycle with `SETTLE=2`: no capture, no `err`.
  - `dig_strobe=11` for one cycle: `err` pulse, and any partial frame is discarded.
- Ordering: units-only strobes in IDLE are ignored, with no `err` and no capture. A tens 3 then tens 2 then units 7 sequence repeated 3 times publishes `value=27`.
- Reset: assert `rst` in HAVE_TENS after 2 stable frames of 12. All outputs return to 0 the next cycle. Publishing requires 3 fresh frames.

Source files
------------

// File: rtl/seg2_capture.sv
// Two-digit multiplexed 7-segment bus reader: decodes tens/units patterns back to a
// binary value 0..59 and publishes it once it has held for STABLE_FRAMES frames.
module seg2_capture #(
   parameter int unsigned STABLE_FRAMES = 3,
   parameter int unsigned SETTLE        = 2,
   parameter int unsigned WIDTH         = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       seg_in,
   input  logic [1:0]       dig_strobe,
   output logic [WIDTH-1:0] value,
   output logic [3:0]       tens_bcd,
   output logic [3:0]       units_bcd,
   output logic             value_valid,
   output logic             update,
   output logic             err
);

   localparam int unsigned SET_W = 8;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] STAB = CNT_W'(STABLE_FRAMES);

   typedef enum logic [0:0] {IDLE, HAVE_TENS} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                strobe_q;
   logic [1:0]                act_q, act_d;
   logic [1:0][SET_W-1:0]     settle_q, settle_d;
   logic [3:0]                tens_q, tens_d;
   logic [WIDTH-1:0]          cand_q, cand_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      pub_q, pub_d;
   logic [WIDTH-1:0]          pub_val_q, pub_val_d;
   logic [3:0]                pub_tens_q, pub_tens_d;
   logic [3:0]                pub_units_q, pub_units_d;
   logic                      err_d;
   logic [1:0]                cap;
   logic [4:0]                dec;
   logic                      legal;
   logic [3:0]                digit;
   logic                      frame;
   logic [WIDTH-1:0]          fval;

   // Pattern to {legal, digit}; anything off-table is illegal.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1111110: decode = {1'b1, 4'd0};
         7'b0110000: decode = {1'b1, 4'd1};
         7'b1101101: decode = {1'b1, 4'd2};
         7'b1111001: decode = {1'b1, 4'd3};
         7'b0110011: decode = {1'b1, 4'd4};
         7'b1011011: decode = {1'b1, 4'd5};
         7'b1011111: decode = {1'b1, 4'd6};
         7'b1110000: decode = {1'b1, 4'd7};
         7'b1111111: decode = {1'b1, 4'd8};
         7'b1111011: decode = {1'b1, 4'd9};
         default:    decode = 5'b0;
      endcase
   endfunction

   // Settle counters, frame FSM and stability tracking.
   always_comb begin
      state_d     = state_q;
      act_d       = act_q;
      settle_d    = settle_q;
      tens_d      = tens_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      pub_d       = 1'b0;
      pub_val_d   = pub_val_q;
      pub_tens_d  = pub_tens_q;
      pub_units_d = pub_units_q;
      err_d       = 1'b0;
      cap         = 2'b00;
      frame       = 1'b0;
      dec         = decode(seg_in);
      legal       = dec[4];
      digit       = dec[3:0];
      fval        = WIDTH'(tens_q) * WIDTH'(10) + WIDTH'(digit);

      if (dig_strobe == 2'b11) begin
         err_d   = 1'b1;
         act_d   = 2'b00;
         state_d = IDLE;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (dig_strobe[i] && !strobe_q[i]) begin
               act_d[i]    = 1'b1;
               settle_d[i] = SET_W'(SETTLE - 1);
            end else if (act_q[i]) begin
               if (!dig_strobe[i]) begin
                  act_d[i] = 1'b0;
               end else if (settle_q[i] == '0) begin
                  cap[i]   = 1'b1;
                  act_d[i] = 1'b0;
               end else begin
                  settle_d[i] = settle_q[i] - 1'b1;
               end
            end
         end

         case (state_q)
            IDLE: begin
               if (cap[1]) begin
                  if (legal && digit <= 4'd5) begin
                     tens_d  = digit;
                     state_d = HAVE_TENS;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            HAVE_TENS: begin
               if (cap[1]) begin
                  if (legal && digit <= 4'd5) begin
                     tens_d = digit;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else if (cap[0]) begin
                  state_d = IDLE;
                  if (legal) frame = 1'b1;
                  else       err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (err_d) begin
         cnt_d = '0;
      end else if (frame) begin
         if (fval == cand_q) begin
            cnt_d = (cnt_q >= STAB) ? STAB : cnt_q + 1'b1;
         end else begin
            cand_d = fval;
            cnt_d  = CNT_W'(1);
         end
         // Publish is staged one cycle so outputs move at C+1.
         if (cnt_d == STAB && (cand_d != value || !value_valid)) begin
            pub_d       = 1'b1;
            pub_val_d   = cand_d;
            pub_tens_d  = tens_q;
            pub_units_d = digit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         strobe_q    <= 2'b00;
         act_q       <= 2'b00;
         settle_q    <= '0;
         tens_q      <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         pub_q       <= 1'b0;
         pub_val_q   <= '0;
         pub_tens_q  <= '0;
         pub_units_q <= '0;
         value       <= '0;
         tens_bcd    <= '0;
         units_bcd   <= '0;
         value_valid <= 1'b0;
         update      <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         strobe_q    <= dig_strobe;
         act_q       <= act_d;
         settle_q    <= settle_d;
         tens_q      <= tens_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         pub_q       <= pub_d;
         pub_val_q   <= pub_val_d;
         pub_tens_q  <= pub_tens_d;
         pub_units_q <= pub_units_d;
         err         <= err_d;
         update      <= pub_q;
         if (pub_q) begin
            value       <= pub_val_q;
            tens_bcd    <= pub_tens_q;
            units_bcd   <= pub_units_q;
            value_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg2_capture.sv
// Directed bench for seg2_capture (SETTLE=2, STABLE_FRAMES=3) with hand-computed
// expectations; update/err pulses are also tallied on the falling edge.
module tb_seg2_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_in;
   logic [1:0] dig_strobe;
   logic [5:0] value;
   logic [3:0] tens_bcd;
   logic [3:0] units_bcd;
   logic       value_valid;
   logic       update;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;
   int err_cnt  = 0;
   int u0, e0;

   logic [6:0] seg_of [10];

   seg2_capture #(.STABLE_FRAMES(3), .SETTLE(2), .WIDTH(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .dig_strobe  (dig_strobe),
      .value       (value),
      .tens_bcd    (tens_bcd),
      .units_bcd   (units_bcd),
      .value_valid (value_valid),
      .update      (update),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (update) upd_cnt++;
      if (err)    err_cnt++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs; returns 1ns after the edge.
   task automatic drive(input logic [1:0] s, input logic [6:0] p);
      dig_strobe = s;
      seg_in     = p;
      @(posedge clk);
      #1;
   endtask

   // Strobe held for 3 edges so the capture lands on the last one.
   task automatic send_digit(input logic [1:0] s, input logic [6:0] p);
      for (int i = 0; i < 3; i++) drive(s, p);
   endtask

   // Full frame; returns 1ns after the units capture edge.
   task automatic frame(input int t, input int u);
      send_digit(2'b10, seg_of[t]);
      drive(2'b00, 7'd0);
      send_digit(2'b01, seg_of[u]);
   endtask

   task automatic frame_blank(input int t, input int u, input int n);
      for (int i = 0; i < n; i++) begin
         frame(t, u);
         drive(2'b00, 7'd0);
      end
   endtask

   initial begin
      seg_of[0] = 7'b1111110; seg_of[1] = 7'b0110000; seg_of[2] = 7'b1101101;
      seg_of[3] = 7'b1111001; seg_of[4] = 7'b0110011; seg_of[5] = 7'b1011011;
      seg_of[6] = 7'b1011111; seg_of[7] = 7'b1110000; seg_of[8] = 7'b1111111;
      seg_of[9] = 7'b1111011;

      rst = 1'b1;
      drive(2'b00, 7'd0);
      drive(2'b00, 7'd0);
      check("rst_value", int'(value), 0);
      check("rst_tens", int'(tens_bcd), 0);
      check("rst_units", int'(units_bcd), 0);
      check("rst_valid", int'(value_valid), 0);
      check("rst_update", int'(update), 0);
      check("rst_err", int'(err), 0);
      rst = 1'b0;
      drive(2'b00, 7'd0);

      // Stable 45: publish one cycle after the 3rd units capture.
      u0 = upd_cnt;
      frame_blank(4, 5, 2);
      check("s45_no_early_update", upd_cnt - u0, 0);
      frame(4, 5);
      check("s45_update_at_C", int'(update), 0);
      check("s45_value_at_C", int'(value), 0);
      drive(2'b00, 7'd0);
      check("s45_update_C1", int'(update), 1);
      check("s45_value", int'(value), 45);
      check("s45_tens", int'(tens_bcd), 4);
      check("s45_units", int'(units_bcd), 5);
      check("s45_valid", int'(value_valid), 1);
      drive(2'b00, 7'd0);
      check("s45_update_drop", int'(update), 0);
      u0 = upd_cnt;
      frame_blank(4, 5, 1);
      drive(2'b00, 7'd0);
      check("s45_repeat_no_update", upd_cnt - u0, 0);

      // Interrupted run of 59, then a full run.
      u0 = upd_cnt;
      frame_blank(5, 9, 2);
      frame_blank(4, 5, 1);
      check("chg_no_update", upd_cnt - u0, 0);
      check("chg_value_hold", int'(value), 45);
      frame_blank(5, 9, 3);
      drive(2'b00, 7'd0);
      check("chg_update", upd_cnt - u0, 1);
      check("chg_value59", int'(value), 59);

      // Illegal tens 6: err one cycle after capture, then clears.
      e0 = err_cnt;
      send_digit(2'b10, seg_of[6]);
      check("ill_tens_err", int'(err), 1);
      drive(2'b00, 7'd0);
      check("ill_tens_err_drop", int'(err), 0);
      e0 = err_cnt - e0;
      check("ill_tens_err_count", e0, 1);

      // Illegal units resets the stability count.
      u0 = upd_cnt; e0 = err_cnt;
      frame_blank(3, 3, 2);
      send_digit(2'b10, seg_of[3]);
      drive(2'b00, 7'd0);
      send_digit(2'b01, 7'b0000001);
      drive(2'b00, 7'd0);
      check("ill_units_err", err_cnt - e0, 1);
      frame_blank(3, 3, 2);
      check("ill_units_no_update", upd_cnt - u0, 0);
      frame_blank(3, 3, 1);
      drive(2'b00, 7'd0);
      check("ill_units_fresh_update", upd_cnt - u0, 1);
      check("ill_units_value33", int'(value), 33);

      // One-cycle tens strobe: no capture, no err.
      u0 = upd_cnt; e0 = err_cnt;
      for (int i = 0; i < 3; i++) begin
         drive(2'b10, seg_of[4]);
         drive(2'b00, 7'd0);
         send_digit(2'b01, seg_of[4]);
         drive(2'b00, 7'd0);
      end
      check("short_strobe_err", err_cnt - e0, 0);
      check("short_strobe_update", upd_cnt - u0, 0);
      check("short_strobe_value", int'(value), 33);

      // Simultaneous strobes discard the partial frame.
      u0 = upd_cnt; e0 = err_cnt;
      frame_blank(4, 4, 2);
      send_digit(2'b10, seg_of[4]);
      drive(2'b11, seg_of[4]);
      check("both_strobe_err", int'(err), 1);
      drive(2'b00, 7'd0);
      send_digit(2'b01, seg_of[4]);
      drive(2'b00, 7'd0);
      drive(2'b00, 7'd0);
      check("both_strobe_err_count", err_cnt - e0, 1);
      check("both_strobe_no_update", upd_cnt - u0, 0);
      frame_blank(4, 4, 3);
      drive(2'b00, 7'd0);
      check("both_strobe_recover", int'(value), 44);

      // Units-only strobes in IDLE are ignored; tens overwrite in HAVE_TENS.
      u0 = upd_cnt; e0 = err_cnt;
      for (int i = 0; i < 3; i++) begin
         send_digit(2'b01, seg_of[7]);
         drive(2'b00, 7'd0);
      end
      check("units_only_err", err_cnt - e0, 0);
      check("units_only_update", upd_cnt - u0, 0);
      for (int i = 0; i < 3; i++) begin
         send_digit(2'b10, seg_of[3]);
         drive(2'b00, 7'd0);
         frame_blank(2, 7, 1);
      end
      drive(2'b00, 7'd0);
      check("order_value27", int'(value), 27);
      check("order_update", upd_cnt - u0, 1);

      // Reset in HAVE_TENS after two frames of 12.
      frame_blank(1, 2, 2);
      send_digit(2'b10, seg_of[1]);
      rst = 1'b1;
      drive(2'b00, 7'd0);
      check("mid_rst_value", int'(value), 0);
      check("mid_rst_valid", int'(value_valid), 0);
      check("mid_rst_tens", int'(tens_bcd), 0);
      rst = 1'b0;
      send_digit(2'b01, seg_of[2]);
      drive(2'b00, 7'd0);
      frame_blank(1, 2, 2);
      drive(2'b00, 7'd0);
      check("post_rst_not_valid", int'(value_valid), 0);
      frame_blank(1, 2, 1);
      drive(2'b00, 7'd0);
      check("post_rst_valid", int'(value_valid), 1);
      check("post_rst_value12", int'(value), 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
